// File: rtl/branch_if.sv
// Control-unit <-> branch unit bundle: request/operand signals in, commit results out.
interface branch_if #(
  parameter int DATA_W = 32,
  parameter int DISP_W = 19
);
  logic              start;
  logic [2:0]        cond;
  logic              link;
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] pc_in;
  logic [DISP_W-1:0] disp;
  logic              busy;
  logic              con_ff;
  logic              done;
  logic              taken;
  logic              illegal;
  logic              pc_we;
  logic [DATA_W-1:0] pc_out;
  logic              link_we;
  logic [DATA_W-1:0] link_val;

  modport master (
    output start, cond, link, ra_val, pc_in, disp,
    input  busy, con_ff, done, taken, illegal, pc_we, pc_out, link_we, link_val
  );

  modport slave (
    input  start, cond, link, ra_val, pc_in, disp,
    output busy, con_ff, done, taken, illegal, pc_we, pc_out, link_we, link_val
  );
endinterface

// File: rtl/branch_unit.sv
// Self-timed conditional branch: capture, evaluate CON_FF, form target, one-cycle commit.
module branch_unit #(
  parameter int DATA_W = 32,
  parameter int DISP_W = 19
) (
  input logic     clk,
  input logic     clr,
  branch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_ADDR   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t            state_r;
  state_t            next_state_s;

  logic [2:0]        cond_r;
  logic              link_r;
  logic [DATA_W-1:0] ra_r;
  logic [DATA_W-1:0] pc_r;
  logic [DISP_W-1:0] disp_r;
  logic              ill_flag_r;
  logic              con_ff_r;
  logic [DATA_W-1:0] pc_out_r;
  logic [DATA_W-1:0] link_val_r;

  logic              busy_r;
  logic              done_r;
  logic              taken_r;
  logic              illegal_r;
  logic              pc_we_r;
  logic              link_we_r;

  logic              cond_eval_s;
  logic              cond_ill_s;
  logic [DATA_W-1:0] target_s;
  logic              commit_next_s;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state sequencing; start only matters in IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          next_state_s = ST_EVAL;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EVAL:   next_state_s = ST_ADDR;
      ST_ADDR:   next_state_s = ST_COMMIT;
      ST_COMMIT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Condition decode on captured operands; illegal codes evaluate as not taken
  always_comb begin
    cond_eval_s = 1'b0;
    cond_ill_s  = 1'b0;
    case (cond_r)
      3'd0:    cond_eval_s = (ra_r == {DATA_W{1'b0}});
      3'd1:    cond_eval_s = (ra_r != {DATA_W{1'b0}});
      3'd2:    cond_eval_s = ~ra_r[DATA_W-1];
      3'd3:    cond_eval_s = ra_r[DATA_W-1];
      3'd4:    cond_eval_s = 1'b1;
      3'd5:    cond_eval_s = 1'b0;
      default: cond_ill_s  = 1'b1;
    endcase
  end

  assign target_s      = pc_r + DATA_W'($signed(disp_r));
  assign commit_next_s = (next_state_s == ST_COMMIT);

  // Operand capture and per-state datapath updates
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cond_r     <= 3'd0;
      link_r     <= 1'b0;
      ra_r       <= {DATA_W{1'b0}};
      pc_r       <= {DATA_W{1'b0}};
      disp_r     <= {DISP_W{1'b0}};
      ill_flag_r <= 1'b0;
      con_ff_r   <= 1'b0;
      pc_out_r   <= {DATA_W{1'b0}};
      link_val_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            cond_r     <= bus.cond;
            link_r     <= bus.link;
            ra_r       <= bus.ra_val;
            pc_r       <= bus.pc_in;
            disp_r     <= bus.disp;
            link_val_r <= bus.pc_in;
          end
        end
        ST_EVAL: begin
          con_ff_r   <= cond_eval_s;
          ill_flag_r <= cond_ill_s;
        end
        ST_ADDR:   pc_out_r <= target_s;
        ST_COMMIT: ill_flag_r <= ill_flag_r;
        default:   ill_flag_r <= 1'b0;
      endcase
    end
  end

  // Registered status/commit strobes, decoded from the upcoming state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      taken_r   <= 1'b0;
      illegal_r <= 1'b0;
      pc_we_r   <= 1'b0;
      link_we_r <= 1'b0;
    end else begin
      busy_r    <= (next_state_s != ST_IDLE);
      done_r    <= commit_next_s;
      taken_r   <= commit_next_s & con_ff_r;
      illegal_r <= commit_next_s & ill_flag_r;
      pc_we_r   <= commit_next_s & con_ff_r;
      link_we_r <= commit_next_s & con_ff_r & link_r;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.con_ff   = con_ff_r;
  assign bus.done     = done_r;
  assign bus.taken    = taken_r;
  assign bus.illegal  = illegal_r;
  assign bus.pc_we    = pc_we_r;
  assign bus.pc_out   = pc_out_r;
  assign bus.link_we  = link_we_r;
  assign bus.link_val = link_val_r;

endmodule

// File: tb/tb_branch_unit.sv
// Randomised and directed checks of branch_unit (32/19 and 16/8) against an arithmetic model.
module tb_branch_unit;

  bit clk = 1'b0;
  logic clr;
  logic clr16;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_if #(.DATA_W(32), .DISP_W(19)) if32 ();
  branch_if #(.DATA_W(16), .DISP_W(8))  if16 ();

  branch_unit #(.DATA_W(32), .DISP_W(19)) dut32 (.clk(clk), .clr(clr),   .bus(if32));
  branch_unit #(.DATA_W(16), .DISP_W(8))  dut16 (.clk(clk), .clr(clr16), .bus(if16));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: branch semantics from the condition rules and modular arithmetic.
  function automatic void ref_model(input int w, input int dw, input logic [2:0] c,
                                    input logic [63:0] ra, input logic [63:0] pc,
                                    input logic [63:0] dsp, output bit con, output bit ill,
                                    output logic [63:0] tgt);
    longint m;
    longint sd;
    longint t;
    m  = longint'(1) << w;
    sd = (dsp >= (64'd1 << (dw - 1))) ? longint'(dsp) - (longint'(1) << dw) : longint'(dsp);
    t  = (longint'(pc) + sd) % m;
    if (t < 0) t = t + m;
    tgt = 64'(t);
    ill = 1'b0;
    case (c)
      3'd0:    con = (ra == 64'd0);
      3'd1:    con = (ra != 64'd0);
      3'd2:    con = (longint'(ra) < m / 2);
      3'd3:    con = (longint'(ra) >= m / 2);
      3'd4:    con = 1'b1;
      3'd5:    con = 1'b0;
      default: begin con = 1'b0; ill = 1'b1; end
    endcase
  endfunction

  function automatic logic [63:0] outs32();
    return 64'({if32.busy, if32.con_ff, if32.done, if32.taken, if32.illegal,
                if32.pc_we, if32.link_we}) | 64'(if32.pc_out) | 64'(if32.link_val);
  endfunction

  task automatic op32(input logic [2:0] c, input bit lk, input logic [31:0] ra,
                      input logic [31:0] pc, input logic [18:0] d, input bit restart);
    bit econ;
    bit eill;
    logic [63:0] etgt;
    ref_model(32, 19, c, 64'(ra), 64'(pc), 64'(d), econ, eill, etgt);
    @(negedge clk);
    if32.start = 1'b1; if32.cond = c; if32.link = lk;
    if32.ra_val = ra; if32.pc_in = pc; if32.disp = d;
    @(negedge clk);
    check_eq("busy_eval", 64'(if32.busy), 64'd1);
    if32.start = restart;
    if32.cond = 3'($urandom); if32.link = 1'($urandom);
    if32.ra_val = $urandom; if32.pc_in = $urandom; if32.disp = 19'($urandom);
    @(negedge clk);
    if32.start = 1'b0;
    check_eq("con_ff", 64'(if32.con_ff), 64'(econ));
    check_eq("done_early", 64'(if32.done), 64'd0);
    @(negedge clk);
    check_eq("done", 64'(if32.done), 64'd1);
    check_eq("taken", 64'(if32.taken), 64'(econ));
    check_eq("pc_we", 64'(if32.pc_we), 64'(econ));
    check_eq("link_we", 64'(if32.link_we), 64'(econ & lk));
    check_eq("illegal", 64'(if32.illegal), 64'(eill));
    check_eq("pc_out", 64'(if32.pc_out), etgt);
    check_eq("link_val", 64'(if32.link_val), 64'(pc));
    @(negedge clk);
    check_eq("done_pulse", 64'({if32.done, if32.pc_we, if32.link_we, if32.illegal, if32.taken}), 64'd0);
    check_eq("busy_after", 64'(if32.busy), 64'd0);
    check_eq("pc_out_hold", 64'(if32.pc_out), etgt);
    check_eq("con_ff_hold", 64'(if32.con_ff), 64'(econ));
  endtask

  initial begin
    logic [31:0] ra;
    bit econ;
    bit eill;
    logic [63:0] etgt;
    int phase;

    clr = 1'b1; clr16 = 1'b1;
    if32.start = 1'b0; if32.cond = 3'd0; if32.link = 1'b0;
    if32.ra_val = 32'd0; if32.pc_in = 32'd0; if32.disp = 19'd0;
    if16.start = 1'b0; if16.cond = 3'd0; if16.link = 1'b0;
    if16.ra_val = 16'd0; if16.pc_in = 16'd0; if16.disp = 8'd0;
    repeat (2) @(negedge clk);
    clr = 1'b0; clr16 = 1'b0;
    check_eq("reset_outs", outs32(), 64'd0);

    // Make outputs non-zero, then assert clr between edges.
    op32(3'd4, 1'b1, 32'h1234, 32'h0000_1000, 19'h00100, 1'b0);
    #2 clr = 1'b1;
    #1 check_eq("async_clr_idle", outs32(), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    // Clear in COMMIT must drop the pulses immediately.
    if32.start = 1'b1; if32.cond = 3'd4; if32.link = 1'b1;
    if32.pc_in = 32'h40; if32.disp = 19'h10;
    @(negedge clk); if32.start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("done_before_clr", 64'(if32.done), 64'd1);
    #2 clr = 1'b1;
    #1 check_eq("async_clr_commit", outs32(), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("idle_quiet", 64'({if32.busy, if32.done, if32.pc_we, if32.link_we, if32.illegal}), 64'd0);
    end

    op32(3'd0, 1'b0, 32'd0, 32'h0000_0010, 19'h00019, 1'b0);
    check_eq("brzr_target", 64'(if32.pc_out), 64'h29);
    op32(3'd2, 1'b1, 32'h8000_0000, 32'h0000_0100, 19'h00040, 1'b1);
    op32(3'd4, 1'b1, 32'h5, 32'h0000_0004, 19'h7FFFC, 1'b0);
    check_eq("wrap_target", 64'(if32.pc_out), 64'h0);

    // Illegal code with start held: accepts every fourth edge.
    @(negedge clk);
    if32.start = 1'b1; if32.cond = 3'd7; if32.link = 1'b1;
    if32.ra_val = 32'd0; if32.pc_in = 32'h100; if32.disp = 19'h8;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      phase = k % 4;
      check_eq("b2b_busy", 64'(if32.busy), 64'(phase != 3));
      check_eq("b2b_done", 64'(if32.done), 64'(phase == 2));
      check_eq("b2b_illegal", 64'(if32.illegal), 64'(phase == 2));
      check_eq("b2b_pc_we", 64'(if32.pc_we), 64'd0);
    end
    if32.start = 1'b0;
    repeat (4) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'd0;
        1:       ra = 32'h8000_0000 | $urandom;
        2:       ra = $urandom & 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      op32(3'($urandom), 1'($urandom), ra, $urandom, 19'($urandom), 1'($urandom));
    end

    // 16/8 instance: clear while in ADDR, then a fresh brnz that wraps.
    @(negedge clk);
    if16.start = 1'b1; if16.cond = 3'd4; if16.link = 1'b1;
    if16.ra_val = 16'd0; if16.pc_in = 16'h0100; if16.disp = 8'h10;
    @(negedge clk); if16.start = 1'b0;
    @(negedge clk);
    clr16 = 1'b1;
    #1 check_eq("w16_clr_busy", 64'(if16.busy), 64'd0);
    @(negedge clk); clr16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("w16_no_commit", 64'({if16.done, if16.pc_we, if16.link_we}), 64'd0);
    end
    ref_model(16, 8, 3'd1, 64'd1, 64'hFFF0, 64'h20, econ, eill, etgt);
    if16.start = 1'b1; if16.cond = 3'd1; if16.link = 1'b0;
    if16.ra_val = 16'd1; if16.pc_in = 16'hFFF0; if16.disp = 8'h20;
    @(negedge clk); if16.start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("w16_done", 64'(if16.done), 64'd1);
    check_eq("w16_pc_we", 64'(if16.pc_we), 64'(econ));
    check_eq("w16_pc_out", 64'(if16.pc_out), etgt);
    check_eq("w16_pc_out_const", 64'(if16.pc_out), 64'h0010);
    @(negedge clk);
    check_eq("w16_done_pulse", 64'(if16.done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised conditional-branch unit for the CPU datapath. It replaces the hand-sequenced CON_FF / PC-out / Y / Z / PC-in branch micro-steps with a self-timed unit. On `start` it captures the condition register value, the current PC and the branch displacement. It then evaluates the condition into an internal CON_FF and computes the target PC. Finally, it issues a one-cycle commit with PC and optional link-register write enables. It sits beside the ALU and is driven by the control unit once per branch instruction.

## Interface
- `DATA_W`, default 32: register and PC width.
- `DISP_W`, default 19: displacement width (C2 field), signed, two's complement; must be ≤ `DATA_W`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `cond`  in  3  condition code: 000 brzr, 001 brnz, 010 brpl, 011 brmi, 100 always, 101 never; 110/111 illegal.
- `link`  in  1  link variant: on a taken branch, also write the return address.
- `ra_val`  in  `DATA_W`  value of the condition register R[a] (named by the Gra field).
- `pc_in`  in  `DATA_W`  current, already-incremented PC.
- `disp`  in  `DISP_W`  signed branch displacement.
- `busy`  out  1  high in every state other than IDLE.
- `con_ff`  out  1  last evaluated condition result.
- `done`  out  1  one-cycle pulse in COMMIT.
- `taken`  out  1  equals `con_ff` while `done` is high; 0 otherwise.
- `illegal`  out  1  one-cycle pulse with `done` when `cond` was 110 or 111.
- `pc_we`  out  1  PC write enable; high in COMMIT iff taken.
- `pc_out`  out  `DATA_W`  registered branch target.
- `link_we`  out  1  link write enable; high in COMMIT iff taken and link.
- `link_val`  out  `DATA_W`  return address (captured `pc_in`).

## Operation
- States: IDLE → EVAL → ADDR → COMMIT → IDLE. There are no other transitions except reset.
- IDLE:
  - If `start`=1 at the edge, capture `cond`, `link`, `ra_val`, `pc_in` and `disp` into operand registers and go to EVAL.
  - Otherwise stay in IDLE.
- EVAL: write `con_ff` from the captured operands according to `cond`:
  - brzr: `ra`==0.
  - brnz: `ra`≠0.
  - brpl: `ra[DATA_W-1]`==0 (zero counts as positive).
  - brmi: `ra[DATA_W-1]`==1.
  - always: 1.
  - never: 0.
  - illegal: 0, and set the illegal flag.
  - Then go to ADDR.
- ADDR:
  - `pc_out` ← captured `pc_in` + sign-extend(`disp`) to `DATA_W`, computed modulo 2^`DATA_W`; overflow wraps silently.
  - Go to COMMIT.
- COMMIT:
  - Assert `done`.
  - Assert `pc_we`=`con_ff`.
  - Assert `link_we`=`con_ff`&`link`.
  - Assert `illegal` if the flag is set.
  - Go to IDLE unconditionally.
- `start` while busy is ignored. It is neither queued nor errored; the requester must re-assert it in IDLE.
- Input changes after the capture edge have no effect on the current operation.
- `con_ff`, `pc_out` and `link_val` hold their values in IDLE until the next operation overwrites them.
- `pc_out` is updated even for not-taken or illegal branches. Consumers qualify it with `pc_we`.
- Reset (`clr`=1, at any time, including mid-operation):
  - State goes to IDLE and all operand registers clear.
  - `con_ff`=0, `pc_out`=0, `link_val`=0.
  - `busy`, `done`, `taken`, `illegal`, `pc_we`, `link_we` = 0.
  - The aborted operation produces no commit.
- After `clr` deasserts, the first edge with `start`=1 is accepted normally.

## Timing
- Start accepted at edge E0 → `busy`=1 after E0 → `con_ff` valid after E1 → `pc_out` valid after E2.
- `done`/`pc_we`/`link_we` are high for exactly the cycle between E2 and E3. This is a latency of 3 cycles from the accepting edge.
- `busy` falls after E3. The earliest next accept is edge E4, giving a throughput of one branch per 4 cycles.
- All outputs are Moore outputs (functions of state and registers only); there are no combinational paths from inputs to outputs.
- `done`, `pc_we`, `link_we` and `illegal` never stay high for more than one cycle.

## Test plan
- Reset and idle checks:
  - Stimulus: assert `clr` asynchronously between edges.
  - Required: all outputs drop to 0 immediately, with no clock edge needed.
  - Then, with `start` held low for 5 cycles after release: `busy` stays 0 and no pulses appear.
- brzr taken, `DATA_W`=32:
  - Stimulus: `ra_val`=0, `pc_in`=0x00000010, `disp`=0x00019.
  - Required: `done` 3 cycles after accept, `pc_we`=1, `pc_out`=0x00000029, `link_we`=0.
- brpl not taken with link, plus ignored start:
  - Stimulus: `ra_val`=0x80000000, `cond`=010, `link`=1; pulse `start` again during EVAL.
  - Required: `con_ff`=0, `pc_we`=0, `link_we`=0, `done` one cycle only; the second `start` does nothing.
- Negative displacement wrap and link:
  - Stimulus: `pc_in`=0x00000004, `disp`=0x7FFFC (-4 in 19 bits), `cond`=100, `link`=1.
  - Required: `pc_out`=0x00000000, `pc_we`=1, `link_we`=1, `link_val`=0x00000004.
- Illegal code and back-to-back:
  - Stimulus: `cond`=111, with `start` held high continuously.
  - Required: `illegal`=1 and `pc_we`=0 in COMMIT, and accepts at E0, E4, E8.
- Reset mid-operation at a non-default width:
  - Stimulus: assert `clr` while in ADDR, with parameters `DATA_W`=16, `DISP_W`=8.
  - Required: no `done`/`pc_we`; a fresh brnz with `ra_val`=1, `pc_in`=0xFFF0, `disp`=0x20 then commits `pc_out`=0x0010 (wrap).
